// File: rtl/piso_pkg.sv
// Shared types and defaults for the piso_tx serial transmitter.
// The FSM state type and the default parameter values live here.
package piso_pkg;

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

   localparam int   DEF_WIDTH      = 4;
   localparam logic DEF_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/piso_tx_bit_tick_div.sv
// Tick counter for piso_tx: counts the clocks of one bit period.
// o_wrap flags the last clock of the period while enabled.
module bit_tick_div #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_wrap
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] r_tick;

   // With CLKS_PER_BIT = 1 LAST is 0 and r_tick never leaves 0, so o_wrap == i_en.
   assign o_wrap = i_en && (r_tick == LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_tick <= '0;
      else if (i_clr || o_wrap)
         r_tick <= '0;
      else if (i_en)
         r_tick <= r_tick + 1'b1;
   end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with valid/ready intake, per-bit clock
// stretching and selectable bit order. A word can chain in the o_done cycle.
module piso_tx
   import piso_pkg::*;
#(
   parameter int   WIDTH        = DEF_WIDTH,
   parameter int   CLKS_PER_BIT = 1,
   parameter int   MSB_FIRST    = 0,
   parameter logic IDLE_LEVEL   = DEF_IDLE_LEVEL
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_sd,
   output logic             o_sv,
   output logic             o_done,
   output logic             o_busy
);

   localparam int BW = $clog2(WIDTH);

   generate
      if (WIDTH < 2 || CLKS_PER_BIT < 1) begin : g_bad_params
         $error("piso_tx: WIDTH must be >= 2 and CLKS_PER_BIT >= 1");
      end
   endgenerate

   state_t           r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [BW-1:0]    r_bitcnt;
   logic             r_sd;
   logic             r_sv;
   logic             r_busy;

   logic             w_shifting;
   logic             w_wrap;
   logic             w_last;
   logic             w_done;
   logic             w_load;
   logic [WIDTH-1:0] w_next;

   function automatic logic first_bit(input logic [WIDTH-1:0] x);
      return (MSB_FIRST != 0) ? x[WIDTH-1] : x[0];
   endfunction

   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] x);
      return (MSB_FIRST != 0) ? {x[WIDTH-2:0], 1'b0} : {1'b0, x[WIDTH-1:1]};
   endfunction

   assign w_shifting = (r_state == ST_SHIFT);
   assign w_last     = (r_bitcnt == BW'(WIDTH - 1));
   assign w_done     = w_shifting && w_wrap && w_last;
   assign w_load     = i_valid && o_ready;
   assign w_next     = shift_word(r_shreg);

   assign o_ready = (r_state == ST_IDLE) || w_done;
   assign o_done  = w_done;
   assign o_sd    = r_sd;
   assign o_sv    = r_sv;
   assign o_busy  = r_busy;

   bit_tick_div #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tick (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (w_shifting),
      .i_clr  (w_load),
      .o_wrap (w_wrap)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_shreg  <= '0;
         r_bitcnt <= '0;
         r_sd     <= IDLE_LEVEL;
         r_sv     <= 1'b0;
         r_busy   <= 1'b0;
      end else if (w_load) begin
         // Loading in the o_done cycle chains the next word with no gap.
         r_state  <= ST_SHIFT;
         r_shreg  <= i_data;
         r_bitcnt <= '0;
         r_sd     <= first_bit(i_data);
         r_sv     <= 1'b1;
         r_busy   <= 1'b1;
      end else if (w_shifting && w_wrap) begin
         if (w_last) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_sd     <= IDLE_LEVEL;
            r_sv     <= 1'b0;
            r_busy   <= 1'b0;
         end else begin
            r_shreg  <= w_next;
            r_bitcnt <= r_bitcnt + 1'b1;
            r_sd     <= first_bit(w_next);
         end
      end
   end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: two configurations share the stimulus, each checked
// every cycle against a queue of expected bit-cycles built from accepted words.
module tb_piso_tx;

   localparam int W = 4;

   typedef struct packed {
      logic sd;
      logic done;
   } exp_t;

   logic         clk   = 1'b0;
   logic         rst   = 1'b0;
   logic         valid = 1'b0;
   logic [W-1:0] data  = '0;
   logic [1:0]   sd, sv, done, busy, ready;

   int   checks = 0;
   int   errors = 0;
   exp_t q[2][$];

   piso_tx #(.WIDTH(W), .CLKS_PER_BIT(1), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u0 (
      .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
      .o_ready(ready[0]), .o_sd(sd[0]), .o_sv(sv[0]), .o_done(done[0]), .o_busy(busy[0]));

   piso_tx #(.WIDTH(W), .CLKS_PER_BIT(3), .MSB_FIRST(1), .IDLE_LEVEL(1'b1)) u1 (
      .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
      .o_ready(ready[1]), .o_sd(sd[1]), .o_sv(sv[1]), .o_done(done[1]), .o_busy(busy[1]));

   always #5 clk = ~clk;

   function automatic int cpb(input int n);
      return (n != 0) ? 3 : 1;
   endfunction

   function automatic bit msb(input int n);
      return n != 0;
   endfunction

   function automatic logic idl(input int n);
      return (n != 0) ? 1'b1 : 1'b0;
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int n = 0; n < 2; n++) begin
         logic act;
         logic e_sd;
         logic e_done;
         act    = (q[n].size() != 0);
         e_sd   = act ? q[n][0].sd : idl(n);
         e_done = act ? q[n][0].done : 1'b0;
         chk($sformatf("%s.u%0d.sd", tag, n), sd[n], e_sd);
         chk($sformatf("%s.u%0d.sv", tag, n), sv[n], act);
         chk($sformatf("%s.u%0d.done", tag, n), done[n], e_done);
         chk($sformatf("%s.u%0d.busy", tag, n), busy[n], act);
         chk($sformatf("%s.u%0d.ready", tag, n), ready[n], !act || e_done);
      end
   endtask

   // A word expands into WIDTH bits, each held for CLKS_PER_BIT cycles.
   task automatic push_word(input int n, input logic [W-1:0] d);
      for (int b = 0; b < W; b++) begin
         int idx;
         idx = msb(n) ? (W - 1 - b) : b;
         for (int t = 0; t < cpb(n); t++) begin
            exp_t e;
            e.sd   = d[idx];
            e.done = (b == W - 1) && (t == cpb(n) - 1);
            q[n].push_back(e);
         end
      end
   endtask

   task automatic cycle(input logic v, input logic [W-1:0] d, input string tag);
      @(negedge clk);
      check_all(tag);
      valid = v;
      data  = d;
      for (int n = 0; n < 2; n++) begin
         logic rdy;
         rdy = (q[n].size() == 0) || q[n][0].done;
         if (q[n].size() != 0) void'(q[n].pop_front());
         if (v && rdy) push_word(n, d);
      end
   endtask

   task automatic async_reset(input string tag);
      @(posedge clk);
      #2 rst = 1'b1;
      valid = 1'b0;
      #1;
      for (int n = 0; n < 2; n++) q[n].delete();
      check_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Reset asserted between edges, checked before any clock edge sees it.
      #3 rst = 1'b1;
      #1 check_all("por");
      @(negedge clk);
      rst = 1'b0;

      cycle(1'b1, 4'b1011, "word_1011");
      repeat (13) cycle(1'b0, 4'h0, "word_1011_tx");

      cycle(1'b1, 4'hA, "b2b_A");
      repeat (14) cycle(1'b1, 4'h5, "b2b_5");
      repeat (14) cycle(1'b0, 4'h0, "b2b_drain");

      cycle(1'b1, 4'hF, "midrst_load");
      cycle(1'b0, 4'h0, "midrst_bit");
      async_reset("midrst_now");
      repeat (8) cycle(1'b0, 4'hF, "midrst_after");

      cycle(1'b1, 4'h9, "bp_load");
      cycle(1'b1, 4'h3, "bp_hold1");
      cycle(1'b1, 4'h6, "bp_hold2");
      cycle(1'b1, 4'hC, "bp_hold3");
      repeat (12) cycle(1'b1, 4'($urandom), "bp_chg");
      repeat (14) cycle(1'b0, 4'h0, "bp_drain");

      repeat (400) begin
         if ($urandom_range(0, 99) == 0)
            async_reset("rnd_rst");
         else
            cycle($urandom_range(0, 3) != 0, 4'($urandom), "rnd");
      end
      repeat (14) cycle(1'b0, 4'h0, "final_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
